// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: enable codes driven by the FSM and
// the BCD digit limits used by the MM:SS.cc counter chain.
package stopwatch_pkg;

  localparam logic [1:0] EN_CLEAR = 2'b00;
  localparam logic [1:0] EN_RUN   = 2'b01;
  localparam logic [1:0] EN_HOLD  = 2'b10;

  localparam logic [3:0] DIG_MAX_DEC = 4'd9;
  localparam logic [3:0] DIG_MAX_SEX = 4'd5;

  // Digit order, least significant first: cs_ones, cs_tens, sec_ones,
  // sec_tens, min_ones, min_tens.
  localparam int NUM_DIGITS = 6;

  function automatic logic [3:0] digit_max(input int idx);
    return (idx == 3 || idx == 5) ? DIG_MAX_SEX : DIG_MAX_DEC;
  endfunction

  // The unused code 2'b11 behaves like clear.
  function automatic logic is_clear(input logic [1:0] en);
    return (en != EN_RUN) && (en != EN_HOLD);
  endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Mode input and time/status outputs of the stopwatch counter, bundled for
// the FSM (master) and the counter (slave).
interface stopwatch_counter_if;
  logic [1:0] en;
  logic [3:0] cs_ones;
  logic [3:0] cs_tens;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       tick;
  logic       overflow;

  modport master (
    output en,
    input  cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens,
    input  tick, overflow
  );

  modport slave (
    input  en,
    output cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens,
    output tick, overflow
  );
endinterface

// File: rtl/stopwatch_tick_gen.sv
// Prescaler dividing the system clock by DIV; tick is the combinational
// increment strobe, high while running on the last prescaler count.
module stopwatch_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] prescale_reg;

  assign tick = run && (prescale_reg == LAST);

  // Neither run nor clr means hold: the partial period is kept for resume.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      prescale_reg <= '0;
    end else if (run) begin
      prescale_reg <= tick ? '0 : prescale_reg + W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Elapsed-time counter MM:SS.cc in six BCD digits, advanced by the prescaler
// strobe, with a sticky overflow flag on the 59:59.99 wrap.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 100
) (
  input  logic                clk,
  input  logic                reset,
  stopwatch_counter_if.slave  sw
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

  logic run;
  logic clr;
  logic inc;

  assign run = (sw.en == EN_RUN);
  assign clr = is_clear(sw.en);

  stopwatch_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .clr   (clr),
    .tick  (inc)
  );

  logic [NUM_DIGITS:0]     carry;
  logic [4*NUM_DIGITS-1:0] digits_reg;
  logic [4*NUM_DIGITS-1:0] digits_next;
  logic                    tick_reg;
  logic                    overflow_reg;

  assign carry[0] = inc;

  // Carry ripples through all digits in one cycle; >= keeps a stray
  // out-of-range value from ever counting past its limit.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [3:0] cur;
    logic       at_max;

    assign cur          = digits_reg[gi*4 +: 4];
    assign at_max       = (cur >= digit_max(gi));
    assign carry[gi+1]  = carry[gi] && at_max;
    assign digits_next[gi*4 +: 4] = clr       ? 4'd0 :
                                    !carry[gi] ? cur  :
                                    at_max    ? 4'd0 : cur + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digits_reg   <= '0;
      tick_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      digits_reg   <= digits_next;
      tick_reg     <= inc;
      overflow_reg <= clr ? 1'b0 : (overflow_reg | carry[NUM_DIGITS]);
    end
  end

  assign sw.cs_ones  = digits_reg[3:0];
  assign sw.cs_tens  = digits_reg[7:4];
  assign sw.sec_ones = digits_reg[11:8];
  assign sw.sec_tens = digits_reg[15:12];
  assign sw.min_ones = digits_reg[19:16];
  assign sw.min_tens = digits_reg[23:20];
  assign sw.tick     = tick_reg;
  assign sw.overflow = overflow_reg;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter with DIV=4: table vectors,
// preloaded wrap/clear sequences and a long random run against a model.
module tb_stopwatch_counter;

  localparam int CLK_FREQ_HZ = 400;
  localparam int TICK_HZ     = 100;
  localparam int DIV         = 4;
  localparam int FULL_SCALE  = 360000;

  logic clk = 1'b0;
  logic reset;

  stopwatch_counter_if sw();

  stopwatch_counter #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .TICK_HZ     (TICK_HZ)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] digits;
    logic        tick;
    logic        ov;
  } exp_t;

  typedef struct {
    logic [1:0]  en;
    int          cycles;
    logic [23:0] exp_digits;
    int          exp_ticks;
    logic        exp_ov;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];

  int   checks   = 0;
  int   failures = 0;
  int   tick_count;
  int   m_pre, m_t;
  logic m_tick, m_ov;
  logic prev_tick = 1'b0;

  function automatic logic [23:0] to_bcd(input int t);
    int mins, secs, cs;
    mins = t / 6000;
    secs = (t / 100) % 60;
    cs   = t % 100;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
            4'(cs / 10), 4'(cs % 10)};
  endfunction

  function automatic logic [23:0] act_digits();
    return {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones,
            sw.cs_tens, sw.cs_ones};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: elapsed time as a plain centisecond count.
  task automatic model_step(input logic rst, input logic [1:0] en);
    exp_t e;
    if (rst || en == 2'b00 || en == 2'b11) begin
      m_pre = 0; m_t = 0; m_tick = 1'b0; m_ov = 1'b0;
    end else if (en == 2'b01) begin
      m_tick = (m_pre == DIV - 1);
      if (m_tick) begin
        m_pre = 0;
        m_t++;
        if (m_t == FULL_SCALE) begin
          m_t  = 0;
          m_ov = 1'b1;
        end
      end else begin
        m_pre++;
      end
    end else begin
      m_tick = 1'b0;
    end
    e.digits = to_bcd(m_t);
    e.tick   = m_tick;
    e.ov     = m_ov;
    sb_q.push_back(e);
  endtask

  task automatic cycle(input logic rst, input logic [1:0] en);
    exp_t e;
    reset = rst;
    sw.en = en;
    model_step(rst, en);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("digits", 32'(act_digits()), 32'(e.digits));
    check("tick", 32'(sw.tick), 32'(e.tick));
    check("overflow", 32'(sw.overflow), 32'(e.ov));
    check("tick_back_to_back", 32'(prev_tick & sw.tick), 32'd0);
    check("tick_outside_run", 32'(sw.tick & (rst | (en != 2'b01))), 32'd0);
    if (sw.tick) tick_count++;
    prev_tick = sw.tick;
  endtask

  // Loads the digit registers through a one-edge override while holding.
  task automatic preload(input logic [23:0] bcd, input int t);
    force dut.digits_next = bcd;
    m_t = t;
    cycle(1'b0, 2'b10);
    release dut.digits_next;
  endtask

  initial begin
    vecs[0] = '{2'b01,   4, 24'h000001,   1, 1'b0};
    vecs[1] = '{2'b00,   1, 24'h000000,   0, 1'b0};
    vecs[2] = '{2'b01, 400, 24'h000100, 100, 1'b0};
    vecs[3] = '{2'b00,   1, 24'h000000,   0, 1'b0};
    vecs[4] = '{2'b01,   2, 24'h000000,   0, 1'b0};
    vecs[5] = '{2'b10,  10, 24'h000000,   0, 1'b0};
    vecs[6] = '{2'b01,   1, 24'h000000,   0, 1'b0};
    vecs[7] = '{2'b01,   1, 24'h000001,   1, 1'b0};
    vecs[8] = '{2'b11,   1, 24'h000000,   0, 1'b0};

    reset = 1'b1;
    sw.en = 2'b01;
    m_pre = 0; m_t = 0; m_tick = 1'b0; m_ov = 1'b0;
    repeat (2) cycle(1'b1, 2'b01);
    check("reset_digits", 32'(act_digits()), 32'd0);
    check("reset_tick", 32'(sw.tick), 32'd0);
    check("reset_overflow", 32'(sw.overflow), 32'd0);

    for (int i = 0; i < 9; i++) begin
      tick_count = 0;
      repeat (vecs[i].cycles) cycle(1'b0, vecs[i].en);
      check($sformatf("vec%0d_digits", i), 32'(act_digits()), 32'(vecs[i].exp_digits));
      check($sformatf("vec%0d_ticks", i), 32'(tick_count), 32'(vecs[i].exp_ticks));
      check($sformatf("vec%0d_overflow", i), 32'(sw.overflow), 32'(vecs[i].exp_ov));
    end

    // Full-scale wrap with prescaler sitting at DIV-1.
    cycle(1'b0, 2'b00);
    repeat (3) cycle(1'b0, 2'b01);
    preload(24'h595999, FULL_SCALE - 1);
    check("preload_digits", 32'(act_digits()), 32'h595999);
    cycle(1'b0, 2'b01);
    check("wrap_digits", 32'(act_digits()), 32'd0);
    check("wrap_overflow", 32'(sw.overflow), 32'd1);
    check("wrap_tick", 32'(sw.tick), 32'd1);
    repeat (3) cycle(1'b0, 2'b10);
    check("hold_keeps_overflow", 32'(sw.overflow), 32'd1);
    cycle(1'b0, 2'b00);
    check("clear_overflow", 32'(sw.overflow), 32'd0);

    // Code 11 clears from 12:34.56.
    preload(24'h123456, 12 * 6000 + 34 * 100 + 56);
    cycle(1'b0, 2'b11);
    check("en11_clear_digits", 32'(act_digits()), 32'd0);

    // Reset mid-count, on the edge that would otherwise increment.
    repeat (7) cycle(1'b0, 2'b01);
    cycle(1'b1, 2'b01);
    check("midreset_digits", 32'(act_digits()), 32'd0);
    check("midreset_tick", 32'(sw.tick), 32'd0);
    check("midreset_overflow", 32'(sw.overflow), 32'd0);

    // Random mode sequence with occasional resets.
    begin
      int   done;
      int   dwell;
      int   r;
      logic [1:0] en_r;
      done = 0;
      while (done < 20000) begin
        r = $urandom_range(0, 9);
        en_r = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 :
               (r <= 3) ? 2'b10 : 2'b01;
        dwell = $urandom_range(1, 60);
        for (int k = 0; k < dwell && done < 20000; k++) begin
          cycle(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0, en_r);
          done++;
        end
      end
    end

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Downstream datapath stage of the stopwatch FSM: consumes the 2-bit enable code and keeps elapsed time as six BCD digits, MM:SS.cc, where cc is centiseconds. It has an internal prescaler that derives a 1/TICK_HZ time base from the system clock. Its digit outputs feed the seven-segment display scanner.

## Interface
- CLK_FREQ_HZ, default 100_000_000: system clock frequency.
- TICK_HZ, default 100: count rate (centiseconds).
- DIV = CLK_FREQ_HZ/TICK_HZ: derived constant, not overridable. Must be an integer ≥ 2.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- en  in  2  mode from FSM: 00 clear, 01 run, 10 hold, 11 treated as clear.
- cs_ones, cs_tens  out  4 each  centisecond BCD digits.
- sec_ones, sec_tens  out  4 each  seconds BCD digits; tens range 0–5.
- min_ones, min_tens  out  4 each  minutes BCD digits; tens range 0–5.
- tick  out  1  one-cycle pulse on each increment edge.
- overflow  out  1  sticky flag; set when 59:59.99 wraps.

## Operation
- Prescaler
  - Width $clog2(DIV).
  - Counts 0..DIV-1 only while en==01, then wraps to 0.
  - Increment condition: en==01 and prescaler==DIV-1.
- Digit chain
  - On each increment, cs_ones increments.
  - Each digit wraps to 0 and carries into the next: cs 9→0, cs_tens 9→0, sec_ones 9→0, sec_tens 5→0, min_ones 9→0, min_tens 5→0.
- Modes
  - Clear (en 00/11): prescaler, all digits, tick and overflow go to 0 on the next edge.
  - Run (en 01): prescaler advances every cycle; digits advance on the increment condition.
  - Hold (en 10): prescaler and digits frozen, tick=0, overflow retained.
- Hold→run resumes from the frozen prescaler value. The partial centisecond is not lost or restarted.
- Full-scale wrap: at 59:59.99 the increment condition takes all digits to 00:00.00 and sets overflow in the same edge. Counting continues.
- overflow clears only on reset or clear mode.
- Digits never hold non-BCD values. No state beyond the prescaler, the six digits and overflow.

## Timing
- All outputs are registered and update on posedge clk.
- Reset and clear values: all digits 0, prescaler 0, tick 0, overflow 0.
- reset has priority over en.
- Run from 00:00.00 with prescaler=0: first increment after exactly DIV run cycles. The edge that sees prescaler==DIV-1 produces cs_ones=1 and tick=1 together.
- tick is high for exactly one cycle per increment. It is never high in hold or clear, and never two cycles in a row (DIV ≥ 2).
- Carry ripple is combinational within one cycle: every affected digit updates on the same edge.
- en change takes effect at the next edge. Run→hold on the edge where the increment condition would hold: en is sampled, so the increment happens only if en==01 at that edge.
- Reset asserted mid-count: all outputs are 0 on the following edge, whatever en is.

## Structure
- Shared package (stopwatch_pkg) holds:
  - en codes EN_CLEAR=2'b00, EN_RUN=2'b01, EN_HOLD=2'b10, which the FSM also uses;
  - digit limits DIG_MAX_DEC=9 and DIG_MAX_SEX=5.
- One sub-module, stopwatch_tick_gen:
  - parameter DIV;
  - inputs clk, reset, run, clr;
  - output tick; contains the prescaler.
- Digit chain and overflow stay in stopwatch_counter: six 4-bit registers with a carry vector.

## Test plan
Bench parameters: CLK_FREQ_HZ=400, TICK_HZ=100, so DIV=4.
- Reset, then en=01 for 4 cycles -> tick pulses once on the 4th edge. Digits read 00:00.01.
- Run 400 cycles from zero -> 00:01.00. Exactly 100 tick pulses. Carry cs 99→00 rolls into sec_ones.
- Run 2 cycles, hold 10 cycles, run 2 cycles -> the first increment occurs on the 2nd cycle after resume. No tick during hold.
- Preload by running to 59:59.99, then one more increment -> 00:00.00, overflow=1. Then en=10 -> overflow stays 1. Then en=00 -> overflow=0 next edge.
- At 12:34.56, apply en=11 -> all digits 0 next edge. Separately, assert reset while en=01 -> all outputs 0 next edge.
- Random en sequence over 20k cycles -> a reference model matches every cycle. tick is never high on two consecutive cycles or outside run mode.
